// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_lock;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  logic        mem_ce;
  logic        mem_r;
  logic        mem_w;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_ce, mem_r, mem_w, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_ce, mem_r, mem_w, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single memory port, one transaction
// at a time, with round-robin or fixed priority and a bounded ownership lock.
module mem_bus_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 0,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);
  localparam logic [3:0] LOCK_MAX  = 4'(MAX_LOCK);
  localparam bit         CPU_WINS  = (CPU_PRIO != 0);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        we_r;
  logic        we_nxt_s;
  logic [15:0] addr_r;
  logic [15:0] addr_nxt_s;
  logic [7:0]  wdata_r;
  logic [7:0]  wdata_nxt_s;
  logic        owner_r;
  logic        owner_nxt_s;
  logic        last_grant_r;
  logic        last_grant_nxt_s;
  logic        lock_r;
  logic        lock_nxt_s;
  logic [3:0]  lock_cnt_r;
  logic [3:0]  lock_cnt_nxt_s;
  logic [2:0]  wait_cnt_r;
  logic [2:0]  wait_cnt_nxt_s;
  logic        rd_cap_s;

  logic        own_req_s;
  logic        oth_req_s;
  logic        own_lock_s;
  logic        keep_lock_s;
  logic        win_s;

  logic        mem_ce_r;
  logic        mem_rd_r;
  logic        mem_wr_r;
  logic        cpu_ack_r;
  logic        dma_ack_r;
  logic [7:0]  cpu_rdata_r;
  logic [7:0]  dma_rdata_r;
  logic        busy_r;

  logic        mem_ce_nxt_s;
  logic        mem_rd_nxt_s;
  logic        mem_wr_nxt_s;
  logic        cpu_ack_nxt_s;
  logic        dma_ack_nxt_s;
  logic [7:0]  cpu_rdata_nxt_s;
  logic [7:0]  dma_rdata_nxt_s;
  logic        busy_nxt_s;

  // State, captured transaction and arbitration bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      addr_r       <= 16'h0000;
      wdata_r      <= 8'h00;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      lock_r       <= 1'b0;
      lock_cnt_r   <= 4'd0;
      wait_cnt_r   <= 3'd0;
    end else begin
      state_r      <= state_nxt_s;
      we_r         <= we_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      lock_r       <= lock_nxt_s;
      lock_cnt_r   <= lock_cnt_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
    end
  end

  // Next-state, winner selection and transaction capture
  always_comb begin
    state_nxt_s      = state_r;
    we_nxt_s         = we_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    owner_nxt_s      = owner_r;
    last_grant_nxt_s = last_grant_r;
    lock_nxt_s       = lock_r;
    lock_cnt_nxt_s   = lock_cnt_r;
    wait_cnt_nxt_s   = wait_cnt_r;
    rd_cap_s         = 1'b0;
    win_s            = owner_r;

    own_req_s   = owner_r ? bus.dma_req  : bus.cpu_req;
    oth_req_s   = owner_r ? bus.cpu_req  : bus.dma_req;
    own_lock_s  = owner_r ? bus.dma_lock : bus.cpu_lock;
    // The lock holder keeps the bus until it stops asking or has starved the other port long enough
    keep_lock_s = lock_r && own_req_s && ((lock_cnt_r < LOCK_MAX) || !oth_req_s);

    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          if (keep_lock_s) begin
            win_s = owner_r;
            if (lock_cnt_r < LOCK_MAX) begin
              lock_cnt_nxt_s = lock_cnt_r + 4'd1;
            end else begin
              lock_cnt_nxt_s = lock_cnt_r;
            end
          end else begin
            lock_nxt_s     = 1'b0;
            lock_cnt_nxt_s = 4'd0;
            if (bus.cpu_req && bus.dma_req) begin
              win_s = CPU_WINS ? 1'b0 : ~last_grant_r;
            end else begin
              win_s = bus.dma_req;
            end
          end
          owner_nxt_s = win_s;
          we_nxt_s    = win_s ? bus.dma_we    : bus.cpu_we;
          addr_nxt_s  = win_s ? bus.dma_addr  : bus.cpu_addr;
          wdata_nxt_s = win_s ? bus.dma_wdata : bus.cpu_wdata;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_r) begin
          state_nxt_s = ST_ACK;
        end else begin
          wait_cnt_nxt_s = WAIT_INIT;
          state_nxt_s    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 3'd0) begin
          rd_cap_s    = 1'b1;
          state_nxt_s = ST_ACK;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 3'd1;
          state_nxt_s    = ST_WAIT;
        end
      end
      ST_ACK: begin
        if (own_lock_s) begin
          lock_nxt_s = 1'b1;
        end else begin
          lock_nxt_s     = 1'b0;
          lock_cnt_nxt_s = 4'd0;
        end
        last_grant_nxt_s = owner_r;
        state_nxt_s      = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the registers line up with it
  always_comb begin
    mem_ce_nxt_s    = (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
    mem_rd_nxt_s    = (state_nxt_s == ST_ISSUE) && !we_nxt_s;
    mem_wr_nxt_s    = (state_nxt_s == ST_ISSUE) && we_nxt_s;
    cpu_ack_nxt_s   = (state_nxt_s == ST_ACK) && !owner_nxt_s;
    dma_ack_nxt_s   = (state_nxt_s == ST_ACK) && owner_nxt_s;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    cpu_rdata_nxt_s = cpu_rdata_r;
    dma_rdata_nxt_s = dma_rdata_r;
    if (rd_cap_s && owner_r) begin
      dma_rdata_nxt_s = bus.mem_rdata;
    end else if (rd_cap_s) begin
      cpu_rdata_nxt_s = bus.mem_rdata;
    end else begin
      cpu_rdata_nxt_s = cpu_rdata_r;
      dma_rdata_nxt_s = dma_rdata_r;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_ce_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dma_ack_r   <= 1'b0;
      cpu_rdata_r <= 8'h00;
      dma_rdata_r <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      mem_ce_r    <= mem_ce_nxt_s;
      mem_rd_r    <= mem_rd_nxt_s;
      mem_wr_r    <= mem_wr_nxt_s;
      cpu_ack_r   <= cpu_ack_nxt_s;
      dma_ack_r   <= dma_ack_nxt_s;
      cpu_rdata_r <= cpu_rdata_nxt_s;
      dma_rdata_r <= dma_rdata_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.mem_ce    = mem_ce_r;
  assign bus.mem_r     = mem_rd_r;
  assign bus.mem_w     = mem_wr_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dma_rdata = dma_rdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: dut0 is round-robin with RD_LAT=2,
// dut1 is CPU-priority with RD_LAT=1; each has a small latency-accurate memory model.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if b0 ();
  mem_bus_arbiter_if b1 ();

  mem_bus_arbiter #(.RD_LAT(2), .CPU_PRIO(0), .MAX_LOCK(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_bus_arbiter #(.RD_LAT(1), .CPU_PRIO(1), .MAX_LOCK(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int err_cnt = 0;
  int chk_cnt = 0;
  int ovl0 = 0;
  int mr0 = 0;
  bit log0[$];
  bit log1[$];
  logic [7:0] rd1[$];

  // Memory contents: 0x0040 holds 0x5C, everything else is addr_lo ^ addr_hi ^ 0x3C
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0040) return 8'h5C;
    else return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic       v0a = 1'b0, v0b = 1'b0, v1 = 1'b0;
  logic [7:0] d0a = 8'h00, d0b = 8'h00, d1 = 8'h00;

  // Read data appears RD_LAT clocks after the read strobe; 0xEE otherwise
  always @(posedge clk) begin
    v0a <= b0.mem_r;
    d0a <= mem_fn(b0.mem_addr);
    v0b <= v0a;
    d0b <= d0a;
    v1  <= b1.mem_r;
    d1  <= mem_fn(b1.mem_addr);
  end
  assign b0.mem_rdata = v0b ? d0b : 8'hEE;
  assign b1.mem_rdata = v1 ? d1 : 8'hEE;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (b0.cpu_ack) log0.push_back(1'b0);
    if (b0.dma_ack) log0.push_back(1'b1);
    if (b0.cpu_ack && b0.dma_ack) ovl0++;
    if (b0.mem_r) mr0++;
    if (b1.cpu_ack) begin
      log1.push_back(1'b0);
      rd1.push_back(b1.cpu_rdata);
    end
    if (b1.dma_ack) log1.push_back(1'b1);
  endtask

  task automatic clear_reqs();
    b0.cpu_req = 1'b0; b0.cpu_we = 1'b0; b0.cpu_lock = 1'b0; b0.cpu_addr = 16'h0; b0.cpu_wdata = 8'h0;
    b0.dma_req = 1'b0; b0.dma_we = 1'b0; b0.dma_lock = 1'b0; b0.dma_addr = 16'h0; b0.dma_wdata = 8'h0;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_lock = 1'b0; b1.cpu_addr = 16'h0; b1.cpu_wdata = 8'h0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_lock = 1'b0; b1.dma_addr = 16'h0; b1.dma_wdata = 8'h0;
  endtask

  bit rr_exp[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit lock_exp[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit prio_exp[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    clear_reqs();
    rst = 1'b0;
    repeat (3) cyc();
    check_eq("rst_busy0", b0.busy, 1'b0);
    check_eq("rst_ce0", b0.mem_ce, 1'b0);
    check_eq("rst_ack0", {b0.cpu_ack, b0.dma_ack}, 2'b00);
    check_eq("rst_owner0", b0.owner, 1'b0);
    check_eq("rst_busy1", b1.busy, 1'b0);
    rst = 1'b1;
    cyc();

    // Single CPU write
    b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h1234; b0.cpu_wdata = 8'hA5;
    cyc();
    check_eq("wr_issue_ce", b0.mem_ce, 1'b1);
    check_eq("wr_issue_w", b0.mem_w, 1'b1);
    check_eq("wr_issue_r", b0.mem_r, 1'b0);
    check_eq("wr_issue_addr", b0.mem_addr, 16'h1234);
    check_eq("wr_issue_wdata", b0.mem_wdata, 8'hA5);
    check_eq("wr_issue_busy", b0.busy, 1'b1);
    check_eq("wr_issue_ack", b0.cpu_ack, 1'b0);
    cyc();
    check_eq("wr_ack_cpu", b0.cpu_ack, 1'b1);
    check_eq("wr_ack_dma", b0.dma_ack, 1'b0);
    check_eq("wr_ack_busy", b0.busy, 1'b1);
    check_eq("wr_ack_w", b0.mem_w, 1'b0);
    b0.cpu_req = 1'b0; b0.cpu_we = 1'b0;
    cyc();
    check_eq("wr_idle_busy", b0.busy, 1'b0);
    check_eq("wr_idle_ack", b0.cpu_ack, 1'b0);

    // DMA read of 0x0040 with RD_LAT=2
    mr0 = 0;
    b0.dma_req = 1'b1; b0.dma_we = 1'b0; b0.dma_addr = 16'h0040;
    cyc();
    check_eq("rd_issue_r", b0.mem_r, 1'b1);
    check_eq("rd_issue_owner", b0.owner, 1'b1);
    check_eq("rd_issue_addr", b0.mem_addr, 16'h0040);
    cyc();
    check_eq("rd_wait1_r", b0.mem_r, 1'b0);
    check_eq("rd_wait1_ce", b0.mem_ce, 1'b1);
    check_eq("rd_wait1_ack", b0.dma_ack, 1'b0);
    cyc();
    check_eq("rd_wait2_ack", b0.dma_ack, 1'b0);
    check_eq("rd_wait2_addr", b0.mem_addr, 16'h0040);
    cyc();
    check_eq("rd_ack_dma", b0.dma_ack, 1'b1);
    check_eq("rd_ack_rdata", b0.dma_rdata, 8'h5C);
    check_eq("rd_ack_cpu", b0.cpu_ack, 1'b0);
    b0.dma_req = 1'b0;
    cyc();
    check_eq("rd_idle_ack", b0.dma_ack, 1'b0);
    check_eq("rd_hold_rdata", b0.dma_rdata, 8'h5C);
    check_eq("rd_strobe_cycles", mr0, 1);

    // Round-robin with both ports requesting continuously
    log0.delete(); ovl0 = 0;
    b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h2000; b0.cpu_wdata = 8'h11;
    b0.dma_req = 1'b1; b0.dma_we = 1'b1; b0.dma_addr = 16'h3000; b0.dma_wdata = 8'h22;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (log0.size() >= 4) break;
    end
    b0.cpu_req = 1'b0; b0.dma_req = 1'b0;
    check_eq("rr_count", log0.size(), 4);
    for (int i = 0; i < 4 && i < log0.size(); i++) check_eq($sformatf("rr_grant%0d", i), log0[i], rr_exp[i]);
    check_eq("rr_overlap", ovl0, 0);
    cyc();

    // DMA lock bounded to MAX_LOCK while the CPU waits
    log0.delete();
    b0.dma_req = 1'b1; b0.dma_lock = 1'b1; b0.dma_we = 1'b1; b0.dma_addr = 16'h4000;
    cyc();
    b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h5000;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (log0.size() >= 6) break;
    end
    b0.cpu_req = 1'b0; b0.dma_req = 1'b0; b0.dma_lock = 1'b0;
    check_eq("lock_count", log0.size(), 6);
    for (int i = 0; i < 6 && i < log0.size(); i++) check_eq($sformatf("lock_grant%0d", i), log0[i], lock_exp[i]);
    cyc(); cyc();

    // Fixed priority: CPU reads win until cpu_req drops, then DMA
    log1.delete(); rd1.delete();
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0100;
    b1.dma_req = 1'b1; b1.dma_we = 1'b1; b1.dma_addr = 16'h0200; b1.dma_wdata = 8'h77;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (log1.size() == 3) b1.cpu_req = 1'b0;
      if (log1.size() >= 4) break;
    end
    b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
    check_eq("prio_count", log1.size(), 4);
    for (int i = 0; i < 4 && i < log1.size(); i++) check_eq($sformatf("prio_grant%0d", i), log1[i], prio_exp[i]);
    if (rd1.size() > 0) check_eq("prio_rdata", rd1[0], 8'h3D);
    else check_eq("prio_rdata_seen", rd1.size(), 1);

    // Reset during the WAIT of a DMA read
    log0.delete();
    b0.dma_req = 1'b1; b0.dma_we = 1'b0; b0.dma_addr = 16'h0040;
    cyc();
    cyc();
    check_eq("mid_busy", b0.busy, 1'b1);
    check_eq("mid_ce", b0.mem_ce, 1'b1);
    rst = 1'b0; b0.dma_req = 1'b0;
    cyc();
    check_eq("mid_rst_busy", b0.busy, 1'b0);
    check_eq("mid_rst_mem", {b0.mem_ce, b0.mem_r, b0.mem_w}, 3'b000);
    check_eq("mid_rst_addr", b0.mem_addr, 16'h0000);
    check_eq("mid_rst_owner", b0.owner, 1'b0);
    check_eq("mid_rst_rdata", b0.dma_rdata, 8'h00);
    rst = 1'b1;
    cyc(); cyc();
    check_eq("mid_rst_no_ack", log0.size(), 0);
    b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h6000;
    b0.dma_req = 1'b1; b0.dma_we = 1'b1; b0.dma_addr = 16'h7000;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (log0.size() >= 1) break;
    end
    b0.cpu_req = 1'b0; b0.dma_req = 1'b0;
    check_eq("post_rst_count", log0.size(), 1);
    if (log0.size() > 0) check_eq("post_rst_winner", log0[0], 1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
